// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_DM = 1'b1
    } owner_t;

    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/mem_arb_timeout.sv
// rtl/mem_arb_timeout.sv - saturating wait counter flagging the final allowed wait cycle
module mem_arb_timeout #(
    parameter int MAX_COUNT = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CW = $clog2(MAX_COUNT + 1);

    logic [CW-1:0] r_count;

    // Count enabled wait cycles; clear restarts, and the value holds at MAX_COUNT instead of wrapping
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != CW'(MAX_COUNT))) begin
            r_count <= r_count + CW'(1);
        end
    end

    // Expired means the current enabled cycle is the MAX_COUNT-th one, so the abort lands on that cycle
    assign o_expired = (r_count >= CW'(MAX_COUNT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data port arbiter onto one memory port; MEM_ARB_ROUND_ROBIN_EN selects round-robin ties
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_if_req,
    input  logic [ADDR_WIDTH-1:0]   i_if_addr,
    output logic                    o_if_gnt,
    output logic                    o_if_rvalid,
    output logic [DATA_WIDTH-1:0]   o_if_rdata,
    output logic                    o_if_err,
    input  logic                    i_dm_req,
    input  logic                    i_dm_we,
    input  logic [DATA_WIDTH/8-1:0] i_dm_be,
    input  logic [ADDR_WIDTH-1:0]   i_dm_addr,
    input  logic [DATA_WIDTH-1:0]   i_dm_wdata,
    output logic                    o_dm_gnt,
    output logic                    o_dm_rvalid,
    output logic [DATA_WIDTH-1:0]   o_dm_rdata,
    output logic                    o_dm_err,
    output logic                    o_mem_req,
    output logic                    o_mem_we,
    output logic [DATA_WIDTH/8-1:0] o_mem_be,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic [DATA_WIDTH-1:0]   o_mem_wdata,
    input  logic                    i_mem_gnt,
    input  logic                    i_mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   i_mem_rdata
);

    state_t r_state;
    owner_t r_owner;
    logic   w_tie_dm;
    logic   w_pick_dm;
    logic   w_any_req;
    logic   w_in_idle;
    logic   w_in_wait;
    logic   w_expired;
    logic   w_done_ok;
    logic   w_done_to;
    logic   w_done;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_t r_last;

    // Remember who won the most recent grant so the next tie goes to the other port
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last <= OWNER_IF;
        end else if (w_in_idle && w_any_req) begin
            r_last <= w_pick_dm ? OWNER_DM : OWNER_IF;
        end
    end

    assign w_tie_dm = (r_last == OWNER_IF);
`else
    assign w_tie_dm = 1'b1;
`endif

    assign w_any_req = i_if_req | i_dm_req;
    assign w_pick_dm = i_dm_req & (~i_if_req | w_tie_dm);

    // Grants and responses are combinational but suppressed while reset is held
    assign w_in_idle = (r_state == ST_IDLE) && !i_rst;
    assign w_in_wait = (r_state == ST_WAIT) && !i_rst;
    assign w_done_ok = w_in_wait && i_mem_rvalid;
    assign w_done_to = w_in_wait && !i_mem_rvalid && w_expired;
    assign w_done    = w_done_ok | w_done_to;

    assign o_if_gnt    = w_in_idle && w_any_req && !w_pick_dm;
    assign o_dm_gnt    = w_in_idle && w_pick_dm;
    assign o_if_rvalid = w_done && (r_owner == OWNER_IF);
    assign o_dm_rvalid = w_done && (r_owner == OWNER_DM);
    assign o_if_err    = w_done_to && (r_owner == OWNER_IF);
    assign o_dm_err    = w_done_to && (r_owner == OWNER_DM);
    assign o_if_rdata  = (w_done_ok && (r_owner == OWNER_IF)) ? i_mem_rdata : '0;
    assign o_dm_rdata  = (w_done_ok && (r_owner == OWNER_DM)) ? i_mem_rdata : '0;

    mem_arb_timeout #(
        .MAX_COUNT (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     ((r_state == ST_REQ) && i_mem_gnt),
        .i_en      ((r_state == ST_WAIT) && !i_mem_rvalid),
        .o_expired (w_expired)
    );

    // Transaction sequencer: latch winner, hold request until accepted, wait for response or abort
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWNER_IF;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_be    <= '0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_state     <= ST_REQ;
                        r_owner     <= w_pick_dm ? OWNER_DM : OWNER_IF;
                        o_mem_req   <= 1'b1;
                        o_mem_we    <= w_pick_dm ? i_dm_we : 1'b0;
                        o_mem_be    <= w_pick_dm ? i_dm_be : '1;
                        o_mem_addr  <= w_pick_dm ? i_dm_addr : i_if_addr;
                        o_mem_wdata <= w_pick_dm ? i_dm_wdata : '0;
                    end
                end
                ST_REQ: begin
                    if (i_mem_gnt) begin
                        r_state   <= ST_WAIT;
                        o_mem_req <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (w_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
